// File: rtl/pn_frame_ctrl.sv
// BDPSK frame sequencer: sync preamble, 7-bit LFSR PN payload, idle gap, valid/ready bit output.
// Optional macro FRAME_REPEAT_EN: GAP loops back to PREAMBLE and the PN sequence runs on across frames.
module pn_frame_ctrl #(
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter logic [31:0] SYNC_WORD    = 32'h0000EB90,
  parameter int unsigned PAYLOAD_LEN  = 127,
  parameter int unsigned GAP_LEN      = 4,
  parameter logic [6:0]  SEED         = 7'h7F
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       seed_load,
  input  logic [6:0] seed_in,
  input  logic       bit_ready,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       frame_done,
  output logic       busy,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    PAYLOAD  = 2'd2,
    GAP      = 2'd3
  } state_t;

  localparam logic [31:0] SYNC = SYNC_WORD;

  state_t     state, state_next;
  logic [6:0] seed_reg;
  logic [6:0] lfsr;
  logic [6:0] lfsr_next;
  logic [4:0] pre_cnt;
  logic [4:0] pre_idx;
  logic [9:0] pay_cnt;
  logic [7:0] gap_cnt;
  logic       first_cyc;
  logic       xfer;
  logic       pre_last, pay_last, gap_last;
  logic       reload;
  logic       kill;

  assign xfer      = bit_valid & bit_ready;
  assign kill      = abort & (state != IDLE);
  assign pre_last  = (pre_cnt == 5'(PREAMBLE_LEN - 1));
  assign pay_last  = (pay_cnt == 10'(PAYLOAD_LEN - 1));
  assign gap_last  = (gap_cnt == 8'(GAP_LEN - 1));
  assign pre_idx   = 5'(PREAMBLE_LEN - 1) - pre_cnt;
  // lfsr[k-1] holds c[k]; feedback c[7]^c[4]^c[3]^c[2] enters at c[1]
  assign lfsr_next = {lfsr[5:0], lfsr[6] ^ lfsr[3] ^ lfsr[2] ^ lfsr[1]};

`ifdef FRAME_REPEAT_EN
  logic first_frame;

  // Only the first frame after IDLE reloads the LFSR; later frames continue the sequence.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_frame <= 1'b0;
    end else if (state == IDLE && start) begin
      first_frame <= 1'b1;
    end else if (state == PREAMBLE && xfer && pre_last && !kill) begin
      first_frame <= 1'b0;
    end
  end

  assign reload = first_frame;
`else
  assign reload = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:     if (start) state_next = PREAMBLE;
        PREAMBLE: if (xfer && pre_last) state_next = PAYLOAD;
        PAYLOAD:  if (xfer && pay_last) state_next = GAP;
        GAP: begin
          if (gap_last) begin
`ifdef FRAME_REPEAT_EN
            state_next = PREAMBLE;
`else
            state_next = IDLE;
`endif
          end
        end
        default:  state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seed_reg  <= SEED;
      lfsr      <= SEED;
      pre_cnt   <= '0;
      pay_cnt   <= '0;
      gap_cnt   <= '0;
      first_cyc <= 1'b0;
    end else begin
      first_cyc <= (state_next == PREAMBLE) && (state != PREAMBLE);
      if (state == IDLE && seed_load) begin
        seed_reg <= (seed_in == '0) ? 7'h01 : seed_in;
      end
      if (kill) begin
        pre_cnt <= '0;
        pay_cnt <= '0;
        gap_cnt <= '0;
      end else begin
        case (state)
          PREAMBLE: begin
            if (xfer) begin
              pre_cnt <= pre_last ? '0 : pre_cnt + 5'd1;
              if (pre_last && reload) lfsr <= seed_reg;
            end
          end
          PAYLOAD: begin
            if (xfer) begin
              pay_cnt <= pay_last ? '0 : pay_cnt + 10'd1;
              lfsr    <= lfsr_next;
            end
          end
          GAP:     gap_cnt <= gap_last ? '0 : gap_cnt + 8'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bit_valid   = 1'b0;
    bit_out     = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    busy        = (state != IDLE);
    case (state)
      PREAMBLE: begin
        bit_valid   = 1'b1;
        bit_out     = SYNC[pre_idx];
        frame_start = first_cyc;
      end
      PAYLOAD: begin
        bit_valid = 1'b1;
        bit_out   = lfsr[6];
      end
      GAP:     frame_done = (gap_cnt == '0);
      default: ;
    endcase
  end

  assign state_o = state;

endmodule

// File: tb/tb_pn_frame_ctrl.sv
// Directed self-checking bench for pn_frame_ctrl in its default (non-repeating) build.
module tb_pn_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, seed_load, bit_ready;
  logic [6:0] seed_in;
  logic       bit_out, bit_valid, frame_start, frame_done, busy;
  logic [1:0] state_o;

  int vectors = 0;
  int miscompares = 0;

  logic [142:0] got_vec;
  int ngot, fs_cnt, fd_cnt, stall_err, done_at, done_cyc, idle_cyc, fd_after;
  logic [1:0] state_at_done;
  logic timeout;

  pn_frame_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .seed_load(seed_load), .seed_in(seed_in), .bit_ready(bit_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .frame_start(frame_start),
    .frame_done(frame_done), .busy(busy), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [142:0] obs, input logic [142:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 16 sync bits EB90 MSB-first, then 127 PN bits of c[7] from the spec recurrence
  function automatic logic [142:0] exp_stream(input logic [6:0] s);
    logic [142:0] v;
    logic [6:0]   c;
    c = s;
    v = '0;
    v[142:127] = 16'hEB90;
    for (int i = 0; i < 127; i++) begin
      v[126 - i] = c[6];
      c = {c[5:0], c[6] ^ c[3] ^ c[2] ^ c[1]};
    end
    return v;
  endfunction

  task automatic run_frame(input logic [6:0] ld_seed, input bit do_ld, input bit rnd,
                           input int abort_at, input int poke_at);
    logic prev_stall, prev_bit;
    seed_in   = ld_seed;
    seed_load = do_ld;
    start     = 1'b1;
    bit_ready = 1'b0;
    tick();
    start     = 1'b0;
    seed_load = 1'b0;
    check("start_valid", bit_valid, 1'b1);
    check("start_state", state_o, 2'd1);
    check("start_pulse", frame_start, 1'b1);
    check("start_bit0", bit_out, 1'b1);
    got_vec = '0; ngot = 0; fs_cnt = 0; fd_cnt = 0; stall_err = 0;
    done_at = -1; done_cyc = -1; idle_cyc = -1; state_at_done = 2'd0; timeout = 1'b0;
    prev_stall = 1'b0; prev_bit = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (prev_stall && (bit_valid !== 1'b1 || bit_out !== prev_bit)) stall_err++;
      if (frame_start) fs_cnt++;
      if (frame_done) begin
        fd_cnt++; done_at = ngot; done_cyc = c; state_at_done = state_o;
      end
      if (!busy) begin
        idle_cyc = c;
        break;
      end
      if (c == poke_at) begin
        start = 1'b1; seed_load = 1'b1; seed_in = 7'h33;
      end else begin
        start = 1'b0; seed_load = 1'b0;
      end
      bit_ready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (bit_valid && bit_ready) begin
        if (ngot == abort_at) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          break;
        end
        if (ngot < 143) got_vec[142 - ngot] = bit_out;
        ngot++;
      end
      prev_stall = bit_valid && !bit_ready;
      prev_bit   = bit_out;
      tick();
      if (c == 1999) timeout = 1'b1;
    end
    start = 1'b0; seed_load = 1'b0; bit_ready = 1'b0;
    check("timeout", timeout, 1'b0);
  endtask

  task automatic check_full(input logic [6:0] seed);
    check("stream", got_vec, exp_stream(seed));
    check("ntransfers", ngot, 143);
    check("done_at", done_at, 143);
    check("gap_len", idle_cyc - done_cyc, 4);
    check("fs_pulses", fs_cnt, 1);
    check("fd_pulses", fd_cnt, 1);
    check("done_state", state_at_done, 2'd3);
    check("stall_hold", stall_err, 0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; seed_load = 1'b0;
    seed_in = 7'h00; bit_ready = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    check("rst_state", state_o, 2'd0);
    check("rst_valid", bit_valid, 1'b0);
    check("rst_bit", bit_out, 1'b0);
    check("rst_fs", frame_start, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_busy", busy, 1'b0);

    // abort while idle is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    check("idle_abort", state_o, 2'd0);

    // scenario 1: ready tied high, reset seed
    run_frame(7'h00, 1'b0, 1'b0, -1, -1);
    check_full(7'h7F);
    check("sync16", got_vec[142:127], 16'hEB90);
    check("pn8_7f", got_vec[126:119], 8'hFE);

    // scenario 2: zero seed stored as 7'h01
    seed_in = 7'h00; seed_load = 1'b1; tick(); seed_load = 1'b0;
    run_frame(7'h00, 1'b0, 1'b0, -1, -1);
    check_full(7'h01);
    check("pn8_01", got_vec[126:119], 8'h02);

    // start and seed_load together: new seed applies to this frame
    run_frame(7'h55, 1'b1, 1'b0, -1, -1);
    check_full(7'h55);
    seed_in = 7'h7F; seed_load = 1'b1; tick(); seed_load = 1'b0;

    // scenario 3: random backpressure
    run_frame(7'h00, 1'b0, 1'b1, -1, -1);
    check_full(7'h7F);

    // scenario 4: abort on the 5th payload transfer
    run_frame(7'h00, 1'b0, 1'b0, 20, -1);
    check("abort_ngot", ngot, 20);
    check("abort_state", state_o, 2'd0);
    check("abort_valid", bit_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    fd_after = 0;
    for (int i = 0; i < 10; i++) begin
      if (frame_done) fd_after++;
      tick();
    end
    check("abort_nodone", fd_after, 0);
    run_frame(7'h00, 1'b0, 1'b0, -1, -1);
    check_full(7'h7F);

    // scenario 5: start/seed_load pokes while busy (preamble, then gap)
    run_frame(7'h00, 1'b0, 1'b0, -1, 3);
    check_full(7'h7F);
    run_frame(7'h00, 1'b0, 1'b0, -1, 145);
    check_full(7'h7F);
    tick();
    check("gap_start_ign", busy, 1'b0);
    run_frame(7'h00, 1'b0, 1'b0, -1, -1);
    check_full(7'h7F);

    // mid-frame reset restores the default seed
    seed_in = 7'h12; seed_load = 1'b1; tick(); seed_load = 1'b0;
    start = 1'b1; bit_ready = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1; bit_ready = 1'b0;
    check("midrst_state", state_o, 2'd0);
    check("midrst_busy", busy, 1'b0);
    run_frame(7'h00, 1'b0, 1'b0, -1, -1);
    check_full(7'h7F);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
